// File: rtl/vga_fill_ctrl.sv
// rtl/vga_fill_ctrl.sv - 80x60 framebuffer write-port owner: CPU direct pixel writes plus a clipped rectangle fill engine
module vga_fill_ctrl #(
  parameter int          FB_W         = 80,
  parameter int          FB_H         = 60,
  parameter logic [31:0] VGA_ADDR_AD  = 32'h11100000,
  parameter logic [31:0] VGA_COLOR_AD = 32'h11140000,
  parameter logic [31:0] FILL_XY_AD   = 32'h11180000,
  parameter logic [31:0] FILL_WH_AD   = 32'h111C0000,
  parameter logic [31:0] FILL_GO_AD   = 32'h11240000,
  parameter logic [31:0] FILL_STAT_AD = 32'h11280000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iobus_addr_i,
  input  logic [31:0] iobus_out_i,
  input  logic        iobus_wr_i,
  output logic [31:0] io_rd_o,
  output logic        io_hit_o,
  output logic [12:0] fb_wa_o,
  output logic [7:0]  fb_wd_o,
  output logic        fb_we_o,
  output logic        busy_o,
  output logic        done_int_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [7:0] FB_W8 = 8'(FB_W);
  localparam logic [7:0] FB_H8 = 8'(FB_H);

  state_t      state_q, state_d;
  logic [12:0] dir_addr_q, dir_addr_d;
  logic [6:0]  cfg_x0_q, cfg_x0_d;
  logic [5:0]  cfg_y0_q, cfg_y0_d;
  logic [6:0]  cfg_w_q, cfg_w_d;
  logic [5:0]  cfg_h_q, cfg_h_d;
  logic [6:0]  x0_q, x0_d;
  logic [7:0]  x_end_q, x_end_d;
  logic [7:0]  y_end_q, y_end_d;
  logic [6:0]  cx_q, cx_d;
  logic [5:0]  cy_q, cy_d;
  logic [7:0]  color_q, color_d;
  logic        done_q, done_d;
  logic        empty_pend_q, empty_pend_d;
  logic [12:0] fb_wa_q, fb_wa_d;
  logic [7:0]  fb_wd_q, fb_wd_d;
  logic        fb_we_q, fb_we_d;

  logic       wr_dir_addr, wr_color, wr_xy, wr_wh, wr_go;
  logic [7:0] x_sum, y_sum, go_x_end, go_y_end;
  logic       go_empty, row_last, col_last;
  logic       unused_bits;

  assign wr_dir_addr = iobus_wr_i && (iobus_addr_i == VGA_ADDR_AD);
  assign wr_color    = iobus_wr_i && (iobus_addr_i == VGA_COLOR_AD);
  assign wr_xy       = iobus_wr_i && (iobus_addr_i == FILL_XY_AD);
  assign wr_wh       = iobus_wr_i && (iobus_addr_i == FILL_WH_AD);
  assign wr_go       = iobus_wr_i && (iobus_addr_i == FILL_GO_AD);
  assign unused_bits = ^iobus_out_i[31:14];

  // Clip against the framebuffer edge; 8-bit sums cannot wrap for 7/6-bit operands.
  assign x_sum    = {1'b0, cfg_x0_q} + {1'b0, cfg_w_q};
  assign y_sum    = {2'b00, cfg_y0_q} + {2'b00, cfg_h_q};
  assign go_x_end = (x_sum > FB_W8) ? FB_W8 : x_sum;
  assign go_y_end = (y_sum > FB_H8) ? FB_H8 : y_sum;
  assign go_empty = (cfg_w_q == 7'd0) || (cfg_h_q == 6'd0) ||
                    ({1'b0, cfg_x0_q} >= FB_W8) || ({2'b00, cfg_y0_q} >= FB_H8);

  assign row_last = ({1'b0, cx_q} == (x_end_q - 8'd1));
  assign col_last = ({2'b00, cy_q} == (y_end_q - 8'd1));

  always_comb begin
    state_d      = state_q;
    dir_addr_d   = dir_addr_q;
    cfg_x0_d     = cfg_x0_q;
    cfg_y0_d     = cfg_y0_q;
    cfg_w_d      = cfg_w_q;
    cfg_h_d      = cfg_h_q;
    x0_d         = x0_q;
    x_end_d      = x_end_q;
    y_end_d      = y_end_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    color_d      = color_q;
    done_d       = done_q;
    empty_pend_d = empty_pend_q;
    fb_wa_d      = fb_wa_q;
    fb_wd_d      = fb_wd_q;
    fb_we_d      = 1'b0;

    if (wr_dir_addr) dir_addr_d = iobus_out_i[12:0];
    if (wr_xy) begin
      cfg_x0_d = iobus_out_i[6:0];
      cfg_y0_d = iobus_out_i[13:8];
    end
    if (wr_wh) begin
      cfg_w_d = iobus_out_i[6:0];
      cfg_h_d = iobus_out_i[13:8];
    end

    // A CPU pixel write owns the port this cycle; the fill cursor holds.
    if (wr_color) begin
      fb_we_d = 1'b1;
      fb_wa_d = dir_addr_q;
      fb_wd_d = iobus_out_i[7:0];
    end else if (state_q == S_RUN) begin
      fb_we_d = 1'b1;
      fb_wa_d = {cy_q, cx_q};
      fb_wd_d = color_q;
      if (row_last) begin
        cx_d = x0_q;
        cy_d = cy_q + 6'd1;
      end else begin
        cx_d = cx_q + 7'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        // An empty rect idles one cycle so DONE lands one edge after GO.
        if (empty_pend_q) begin
          empty_pend_d = 1'b0;
          state_d      = S_DONE;
          done_d       = 1'b1;
        end else if (wr_go) begin
          color_d = iobus_out_i[7:0];
          x0_d    = cfg_x0_q;
          x_end_d = go_x_end;
          y_end_d = go_y_end;
          cx_d    = cfg_x0_q;
          cy_d    = cfg_y0_q;
          done_d  = 1'b0;
          if (go_empty) empty_pend_d = 1'b1;
          else          state_d      = S_RUN;
        end
      end
      S_RUN: begin
        if (!wr_color && row_last && col_last) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      dir_addr_q   <= '0;
      cfg_x0_q     <= '0;
      cfg_y0_q     <= '0;
      cfg_w_q      <= '0;
      cfg_h_q      <= '0;
      x0_q         <= '0;
      x_end_q      <= '0;
      y_end_q      <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      color_q      <= '0;
      done_q       <= 1'b0;
      empty_pend_q <= 1'b0;
      fb_wa_q      <= '0;
      fb_wd_q      <= '0;
      fb_we_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_addr_q   <= dir_addr_d;
      cfg_x0_q     <= cfg_x0_d;
      cfg_y0_q     <= cfg_y0_d;
      cfg_w_q      <= cfg_w_d;
      cfg_h_q      <= cfg_h_d;
      x0_q         <= x0_d;
      x_end_q      <= x_end_d;
      y_end_q      <= y_end_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      color_q      <= color_d;
      done_q       <= done_d;
      empty_pend_q <= empty_pend_d;
      fb_wa_q      <= fb_wa_d;
      fb_wd_q      <= fb_wd_d;
      fb_we_q      <= fb_we_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_int_o = (state_q == S_DONE);
  assign fb_wa_o    = fb_wa_q;
  assign fb_wd_o    = fb_wd_q;
  assign fb_we_o    = fb_we_q;
  assign io_hit_o   = (iobus_addr_i == FILL_STAT_AD);
  assign io_rd_o    = io_hit_o ? {30'd0, done_q, busy_o} : 32'd0;

endmodule

// File: tb/tb_vga_fill_ctrl.sv
// tb/tb_vga_fill_ctrl.sv - directed and randomized bench for vga_fill_ctrl against a pixel-list reference model
module tb_vga_fill_ctrl;

  localparam logic [31:0] A_ADDR  = 32'h11100000;
  localparam logic [31:0] A_COLOR = 32'h11140000;
  localparam logic [31:0] A_XY    = 32'h11180000;
  localparam logic [31:0] A_WH    = 32'h111C0000;
  localparam logic [31:0] A_GO    = 32'h11240000;
  localparam logic [31:0] A_STAT  = 32'h11280000;
  localparam int          NO_RST  = 1 << 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] iobus_addr = '0;
  logic [31:0] iobus_out = '0;
  logic        iobus_wr = 1'b0;
  logic [31:0] io_rd;
  logic        io_hit;
  logic [12:0] fb_wa;
  logic [7:0]  fb_wd;
  logic        fb_we;
  logic        busy;
  logic        done_int;

  vga_fill_ctrl dut (
    .clk_i(clk), .rst_i(rst), .iobus_addr_i(iobus_addr), .iobus_out_i(iobus_out),
    .iobus_wr_i(iobus_wr), .io_rd_o(io_rd), .io_hit_o(io_hit), .fb_wa_o(fb_wa),
    .fb_wd_o(fb_wd), .fb_we_o(fb_we), .busy_o(busy), .done_int_o(done_int)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int e;
    int wa;
    int wd;
  } wr_t;

  wr_t obs_q[$];
  int  done_q[$];

  always @(negedge clk) begin
    wr_t w;
    if (fb_we) begin
      w.e = cyc; w.wa = int'(fb_wa); w.wd = int'(fb_wd);
      obs_q.push_back(w);
    end
    if (done_int) done_q.push_back(cyc);
  end

  // Reference model: register file, direct-write log, and the latched fill request.
  int  m_dir, m_x0, m_y0, m_w, m_h;
  bit  m_sticky, m_active;
  int  m_k, f_x0, f_y0, f_w, f_h, f_col;
  wr_t m_dir_q[$];
  int  scen_start;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] pack(input wr_t w);
    return 32'(((w.e - scen_start) & 2047) << 21) | 32'((w.wa & 8191) << 8) | 32'(w.wd & 255);
  endfunction

  task automatic model_reset();
    m_dir = 0; m_x0 = 0; m_y0 = 0; m_w = 0; m_h = 0; m_sticky = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    int  edge_e;
    wr_t w;
    edge_e = cyc + 1;
    iobus_addr = a; iobus_out = d; iobus_wr = 1'b1;
    case (a)
      A_ADDR:  m_dir = int'(d[12:0]);
      A_COLOR: begin w.e = edge_e; w.wa = m_dir; w.wd = int'(d[7:0]); m_dir_q.push_back(w); end
      A_XY:    begin m_x0 = int'(d[6:0]); m_y0 = int'(d[13:8]); end
      A_WH:    begin m_w = int'(d[6:0]);  m_h = int'(d[13:8]); end
      A_GO: if (!m_active) begin
        m_active = 1'b1; m_k = edge_e; f_col = int'(d[7:0]);
        f_x0 = m_x0; f_y0 = m_y0; f_w = m_w; f_h = m_h; m_sticky = 1'b0;
      end
      default: ;
    endcase
    @(negedge clk);
    iobus_wr = 1'b0;
  endtask

  task automatic bus_idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(output int cutoff);
    rst = 1'b1;
    cutoff = cyc + 1;
    @(negedge clk);
    chk("rst fb_we", 32'(fb_we), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done_int", 32'(done_int), 0);
    iobus_addr = A_STAT; #1;
    chk("rst stat", io_rd, 0);
    iobus_addr = '0;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic finish_scn(input string tag, input int cutoff);
    wr_t exp_q[$];
    wr_t w;
    int  px[$];
    int  dedge, idx, di, e, xe, ye, expd;
    dedge = -1;
    if (m_active) begin
      xe = (f_x0 + f_w < 80) ? f_x0 + f_w : 80;
      ye = (f_y0 + f_h < 60) ? f_y0 + f_h : 60;
      for (int y = f_y0; y < ye; y++)
        for (int x = f_x0; x < xe; x++) px.push_back(y * 128 + x);
      if (px.size() == 0) dedge = m_k + 1;
    end
    idx = 0; di = 0; e = scen_start;
    while (((m_active && idx < px.size()) || di < m_dir_q.size()) && e < scen_start + 4000) begin
      if (di < m_dir_q.size() && m_dir_q[di].e == e) begin
        exp_q.push_back(m_dir_q[di]); di++;
      end else if (m_active && e > m_k && idx < px.size()) begin
        w.e = e; w.wa = px[idx]; w.wd = f_col; exp_q.push_back(w); idx++;
        if (idx == px.size()) dedge = e;
      end
      e++;
    end
    while (exp_q.size() > 0 && exp_q[$].e >= cutoff) void'(exp_q.pop_back());
    expd = (dedge >= 0 && dedge < cutoff) ? 1 : 0;
    if (dedge > e) e = dedge;
    while (cyc < e + 2) @(negedge clk);

    chk({tag, " nwr"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, " wr"}, pack(obs_q[i]), pack(exp_q[i]));
    chk({tag, " ndone"}, done_q.size(), expd);
    if (expd == 1 && done_q.size() == 1)
      chk({tag, " done_edge"}, done_q[0] - scen_start, dedge - scen_start);
    chk({tag, " busy"}, 32'(busy), 0);
    if (cutoff != NO_RST) m_sticky = 1'b0;
    else if (m_active)    m_sticky = (expd == 1);
    iobus_addr = A_STAT; #1;
    chk({tag, " stat"}, io_rd, {30'd0, m_sticky, 1'b0});
    chk({tag, " hit"}, 32'(io_hit), 1);
    iobus_addr = A_XY; #1;
    chk({tag, " rd_other"}, io_rd, 0);
    iobus_addr = '0;
    obs_q.delete(); done_q.delete(); m_dir_q.delete();
    m_active = 1'b0;
    scen_start = cyc + 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: cycle %0d reached, bench end required earlier", cyc);
    $fatal(1);
  end

  initial begin
    int cut;
    model_reset();
    m_active = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset fb_we", 32'(fb_we), 0);
    chk("reset fb_wa", 32'(fb_wa), 0);
    chk("reset fb_wd", 32'(fb_wd), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset done_int", 32'(done_int), 0);
    rst = 1'b0;
    @(negedge clk);
    scen_start = cyc + 1;

    // Basic 3x2 fill
    bus_wr(A_XY, 32'h0000_050A); bus_wr(A_WH, 32'h0000_0203); bus_wr(A_GO, 32'hE0);
    chk("t2 busy", 32'(busy), 1);
    finish_scn("t2", NO_RST);

    // Bottom-right clipping
    bus_wr(A_XY, 32'h0000_3B4E); bus_wr(A_WH, 32'h0000_0505); bus_wr(A_GO, 32'h1C);
    finish_scn("t3", NO_RST);

    // Direct write interleaved into a running fill
    bus_wr(A_XY, 32'h0000_050A); bus_wr(A_WH, 32'h0000_0203); bus_wr(A_GO, 32'hE0);
    bus_wr(A_ADDR, 32'h0001); bus_wr(A_COLOR, 32'h03);
    finish_scn("t4", NO_RST);

    // Zero-width rect and GO while busy
    bus_wr(A_WH, 32'h0000_0400); bus_wr(A_GO, 32'h77);
    finish_scn("t5a", NO_RST);
    bus_wr(A_XY, 32'h0000_050A); bus_wr(A_WH, 32'h0000_0203); bus_wr(A_GO, 32'hE0);
    bus_idle(1); bus_wr(A_GO, 32'h55);
    finish_scn("t5b", NO_RST);

    // Reset after the third pixel, then a normal fill
    bus_wr(A_XY, 32'h0000_050A); bus_wr(A_WH, 32'h0000_0203); bus_wr(A_GO, 32'hE0);
    bus_idle(3);
    do_reset(cut);
    finish_scn("t6 abort", cut);
    bus_wr(A_XY, 32'h0000_0102); bus_wr(A_WH, 32'h0000_0202); bus_wr(A_GO, 32'h42);
    finish_scn("t6 after", NO_RST);

    // Reset while an empty rect is pending completion
    bus_wr(A_XY, 32'h0000_0050); bus_wr(A_WH, 32'h0000_0101); bus_wr(A_GO, 32'h11);
    do_reset(cut);
    finish_scn("t1 empty", cut);

    // Randomized fills with random interleaved CPU pixel writes
    for (int it = 0; it < 24; it++) begin
      bus_wr(A_XY, {18'd0, 6'($urandom_range(0, 63)), 1'b0, 7'($urandom_range(0, 90))});
      bus_wr(A_WH, {18'd0, 6'($urandom_range(0, 10)), 1'b0, 7'($urandom_range(0, 24))});
      if ($urandom_range(0, 1) == 1) bus_wr(A_ADDR, 32'($urandom_range(0, 8191)));
      bus_wr(A_GO, 32'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          bus_idle($urandom_range(0, 4));
          bus_wr(A_COLOR, 32'($urandom_range(0, 255)));
        end
      end
      finish_scn("rand", NO_RST);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
